// File: rtl/branch_redirect_pkg.sv
// Shared types and default widths for the branch redirect unit.
package branch_redirect_pkg;

  localparam int unsigned PC_W_DEF   = 33;
  localparam int unsigned IMM_W_DEF  = 16;
  localparam int unsigned JTGT_W_DEF = 26;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned TAG_W_DEF  = 5;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    PEND   = 2'd1,
    TAKEN  = 2'd2,
    NTAKEN = 2'd3
  } entry_state_e;

  typedef struct packed {
    entry_state_e            state;
    logic [TAG_W_DEF-1:0]    tag;
    logic [PC_W_DEF-1:0]     target;
  } entry_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational jump (pseudo-direct) and branch (PC-relative, word-scaled) target.
module branch_target_calc
  import branch_redirect_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned IMM_W  = IMM_W_DEF,
  parameter int unsigned JTGT_W = JTGT_W_DEF
) (
  input  logic              is_jump,
  input  logic [PC_W-1:0]   pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JTGT_W-1:0] jtgt,
  output logic [PC_W-1:0]   target
);

  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;

  generate
    if (JTGT_W + 2 < PC_W) begin : g_jump_upper
      always_comb jump_target = {pc[PC_W-1:JTGT_W+2], jtgt, 2'b00};
    end else begin : g_jump_full
      always_comb jump_target = {jtgt, 2'b00};
    end
  endgenerate

  always_comb begin
    imm_sext      = PC_W'($signed(imm));
    branch_target = pc + {imm_sext[PC_W-3:0], 2'b00};
    target        = is_jump ? jump_target : branch_target;
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// In-order control-flow tracking queue: resolves branches from the CDB and
// issues redirects to the IFQ, squashing younger wrong-path entries.
module branch_redirect_unit
  import branch_redirect_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned IMM_W  = IMM_W_DEF,
  parameter int unsigned JTGT_W = JTGT_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic                     disp_is_jump,
  input  logic [PC_W-1:0]          disp_pc,
  input  logic [IMM_W-1:0]         disp_imm,
  input  logic [JTGT_W-1:0]        disp_jtgt,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic                     cdb_taken,
  output logic                     redir_valid,
  input  logic                     redir_ready,
  output logic [PC_W-1:0]          redir_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    entry_state_e       state;
    logic [TAG_W-1:0]   tag;
    logic [PC_W-1:0]    target;
  } slot_t;

  slot_t            q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PC_W-1:0]  disp_target;
  entry_state_e     head_state;
  logic             disp_fire;
  logic             pop_silent;
  logic             redirect;

  branch_target_calc #(
    .PC_W   (PC_W),
    .IMM_W  (IMM_W),
    .JTGT_W (JTGT_W)
  ) u_target_calc (
    .is_jump (disp_is_jump),
    .pc      (disp_pc),
    .imm     (disp_imm),
    .jtgt    (disp_jtgt),
    .target  (disp_target)
  );

  // An empty queue has a FREE head, so head state alone decides redir_valid.
  always_comb begin
    head_state  = q[head].state;
    disp_ready  = (count < CNT_W'(DEPTH));
    redir_valid = (head_state == TAKEN);
    redir_addr  = redir_valid ? q[head].target : '0;
    disp_fire   = disp_valid && disp_ready;
    pop_silent  = (head_state == NTAKEN);
    redirect    = redir_valid && redir_ready;
  end

  always_ff @(posedge clock) begin
    if (reset || flush || redirect) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[PTR_W'(i)].state <= FREE;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // The tail slot is FREE, so a same-cycle dispatch can never match here.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cdb_valid && q[PTR_W'(i)].state == PEND && q[PTR_W'(i)].tag == cdb_tag) begin
          q[PTR_W'(i)].state <= cdb_taken ? TAKEN : NTAKEN;
        end
      end
      if (pop_silent) begin
        q[head].state <= FREE;
        head          <= head + PTR_W'(1);
      end
      if (disp_fire) begin
        q[tail] <= '{state:  (disp_is_jump ? TAKEN : PEND),
                     tag:    disp_tag,
                     target: disp_target};
        tail    <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(disp_fire) - CNT_W'(pop_silent);
    end
  end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit against a queue-based reference model.
module tb_branch_redirect_unit;

  localparam int PC_W   = 33;
  localparam int IMM_W  = 16;
  localparam int JTGT_W = 26;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 5;

  logic              clock = 1'b0;
  logic              reset, flush;
  logic              disp_valid, disp_ready, disp_is_jump;
  logic [PC_W-1:0]   disp_pc;
  logic [IMM_W-1:0]  disp_imm;
  logic [JTGT_W-1:0] disp_jtgt;
  logic [TAG_W-1:0]  disp_tag;
  logic              cdb_valid, cdb_taken;
  logic [TAG_W-1:0]  cdb_tag;
  logic              redir_valid, redir_ready;
  logic [PC_W-1:0]   redir_addr;
  logic [$clog2(DEPTH):0] count;

  branch_redirect_unit #(
    .PC_W(PC_W), .IMM_W(IMM_W), .JTGT_W(JTGT_W), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_jump(disp_is_jump),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_jtgt(disp_jtgt), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_taken(cdb_taken),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_addr(redir_addr),
    .count(count)
  );

  always #5 clock = ~clock;

  // Model entry: st 0 = waiting, 1 = will redirect, 2 = will be dropped.
  typedef struct {
    int               st;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } ment_t;

  ment_t           mq[$];
  logic [PC_W-1:0] exp_q[$];
  int              tests = 0;
  int              fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PC_W-1:0] ref_target(input bit j, input logic [PC_W-1:0] pc,
                                                 input logic [IMM_W-1:0] imm,
                                                 input logic [JTGT_W-1:0] jt);
    longint unsigned p, r, mask;
    longint          s;
    p    = pc;
    mask = (64'd1 << PC_W) - 1;
    if (j) begin
      r = (p & ~((64'd1 << (JTGT_W + 2)) - 1)) | (longint'(jt) * 4);
    end else begin
      s = $signed(imm);
      r = p + longint'(s * 4);
    end
    return PC_W'(r & mask);
  endfunction

  function automatic bit m_rv();
    return (mq.size() > 0) && (mq[0].st == 1);
  endfunction

  function automatic bit tag_live(input logic [TAG_W-1:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  // Predicts the effect of the next rising edge given the current inputs.
  task automatic model_step();
    bit rdy, pop;
    if (reset || flush) begin
      mq.delete();
    end else if (m_rv() && redir_ready) begin
      exp_q.push_back(mq[0].target);
      mq.delete();
    end else begin
      rdy = mq.size() < DEPTH;
      pop = (mq.size() > 0) && (mq[0].st == 2);
      if (cdb_valid)
        foreach (mq[i])
          if (mq[i].st == 0 && mq[i].tag == cdb_tag) mq[i].st = cdb_taken ? 1 : 2;
      if (pop) void'(mq.pop_front());
      if (disp_valid && rdy)
        mq.push_back('{st: (disp_is_jump ? 1 : 0), tag: disp_tag,
                       target: ref_target(disp_is_jump, disp_pc, disp_imm, disp_jtgt)});
    end
  endtask

  task automatic idle();
    reset = 0; flush = 0; disp_valid = 0; disp_is_jump = 0;
    disp_pc = '0; disp_imm = '0; disp_jtgt = '0; disp_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_taken = 0; redir_ready = 0;
  endtask

  task automatic set_disp(input bit j, input logic [PC_W-1:0] pc, input logic [IMM_W-1:0] imm,
                          input logic [JTGT_W-1:0] jt, input logic [TAG_W-1:0] t);
    disp_valid = 1; disp_is_jump = j; disp_pc = pc; disp_imm = imm; disp_jtgt = jt; disp_tag = t;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] t, input bit tk);
    cdb_valid = 1; cdb_tag = t; cdb_taken = tk;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("redir_valid", redir_valid, m_rv());
    chk("redir_addr", redir_addr, m_rv() ? mq[0].target : '0);
    chk("count", count, mq.size());
    chk("disp_ready", disp_ready, mq.size() < DEPTH);
    idle();
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (redir_valid && redir_ready && !reset && !flush) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL redir_unexpected: got %h expected no redirect", redir_addr);
        end else begin
          chk("redir_scoreboard", redir_addr, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    logic [TAG_W-1:0] t;
    int pend_idx[$];
    idle();
    reset = 1; tick();
    reset = 1; tick();
    chk("reset_count", count, 0);
    chk("reset_ready", disp_ready, 1);
    chk("reset_rv", redir_valid, 0);
    chk("reset_addr", redir_addr, 0);

    // Jump into empty queue: redirect visible one cycle later.
    set_disp(1, 33'h0_0040_0010, '0, 26'h0100040, 0); tick();
    chk("jump_rv", redir_valid, 1);
    chk("jump_addr", redir_addr, 33'h0_0040_0100);
    redir_ready = 1; tick();
    chk("jump_count", count, 0);

    // Backward then forward branch.
    set_disp(0, 33'h1000, 16'hFFFC, '0, 3); tick();
    tick();
    set_cdb(3, 1); tick();
    chk("bwd_addr", redir_addr, 33'h0FF0);
    redir_ready = 1; tick();
    set_disp(0, 33'h1000, 16'h0004, '0, 3); tick();
    set_cdb(3, 1); tick();
    chk("fwd_addr", redir_addr, 33'h1010);
    redir_ready = 1; tick();

    // Out-of-order resolution.
    set_disp(0, 33'h2000, 16'h0001, '0, 1); tick();
    set_disp(0, 33'h2000, 16'h0002, '0, 2); tick();
    set_disp(0, 33'h2000, 16'h0003, '0, 3); tick();
    set_cdb(3, 1); tick();
    set_cdb(2, 0); tick();
    set_cdb(1, 0); tick();
    for (int i = 0; i < 4; i++) begin redir_ready = 1; tick(); end
    chk("ooo_count", count, 0);

    // Squash with simultaneous dispatch.
    set_disp(0, 33'h3000, 16'h0008, '0, 4); tick();
    set_disp(1, 33'h3000, '0, 26'h0000123, 5); tick();
    set_cdb(4, 1); tick();
    chk("squash_addr", redir_addr, 33'h3020);
    redir_ready = 1; set_disp(0, 33'h4000, 16'h0001, '0, 6); tick();
    chk("squash_count", count, 0);

    // Full queue and backpressure.
    for (int i = 0; i < 4; i++) begin
      set_disp(0, 33'h5000, 16'(i), '0, TAG_W'(8 + i)); tick();
    end
    chk("full_ready", disp_ready, 0);
    set_disp(0, 33'h5000, '0, '0, 12); tick();
    chk("full_count", count, 4);
    set_cdb(8, 0); set_disp(0, 33'h5000, '0, '0, 12); tick();
    set_disp(0, 33'h5000, '0, '0, 12); tick();
    set_disp(0, 33'h5000, '0, '0, 12); tick();
    chk("refill_count", count, 4);

    // Flush, then reset, while a redirect is held.
    flush = 1; tick();
    set_disp(1, 33'h0_0040_0010, '0, 26'h0000040, 1); tick();
    chk("hold_rv", redir_valid, 1);
    flush = 1; tick();
    chk("flush_rv", redir_valid, 0);
    chk("flush_count", count, 0);
    set_disp(1, 33'h0_0040_0010, '0, 26'h0000040, 1); tick();
    reset = 1; tick();
    chk("rst_rv", redir_valid, 0);
    chk("rst_ready", disp_ready, 1);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 99) < 2);
      redir_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 6) begin
        do t = TAG_W'($urandom()); while (tag_live(t));
        set_disp($urandom_range(0, 9) < 3, PC_W'({$urandom(), $urandom()}),
                 IMM_W'($urandom()), JTGT_W'($urandom()), t);
      end
      if ($urandom_range(0, 9) < 4) begin
        pend_idx.delete();
        foreach (mq[i]) if (mq[i].st == 0) pend_idx.push_back(i);
        if (pend_idx.size() > 0 && $urandom_range(0, 3) != 0)
          t = mq[pend_idx[$urandom_range(0, pend_idx.size() - 1)]].tag;
        else
          t = TAG_W'($urandom());
        if (!(disp_valid && t == disp_tag)) set_cdb(t, $urandom_range(0, 1));
      end
      tick();
    end

    tick();
    tick();
    @(negedge clock);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Parametrised successor to the dispatch-stage jump/branch address logic.
- Computes jump targets (pseudo-direct) and branch targets (sign-extended, word-scaled), then holds each in an in-order tracking queue until resolved.
- Issues redirects to the IFQ over a valid/ready handshake and squashes younger wrong-path entries on each taken redirect.
- Sits between the dispatch unit, the CDB and the IFQ.

Parameters:
- PC_W, 33, PC/target width.
- IMM_W, 16, branch immediate width.
- JTGT_W, 26, jump target field width; requires JTGT_W+2 <= PC_W.
- DEPTH, 4, tracking-queue entries; power of two, >= 2.
- TAG_W, 5, ROB tag width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  external pipeline flush; clears all entries.
- disp_valid  in  1  dispatch presents a control-flow instruction.
- disp_ready  out  1  queue can accept; equals (count < DEPTH).
- disp_is_jump  in  1  1 = jump (always taken), 0 = conditional branch.
- disp_pc  in  PC_W  PC of the delay-slot/next instruction (PC+4).
- disp_imm  in  IMM_W  branch offset, in words, signed.
- disp_jtgt  in  JTGT_W  jump target field.
- disp_tag  in  TAG_W  ROB tag; unique among live entries.
- cdb_valid  in  1  branch resolution broadcast.
- cdb_tag  in  TAG_W  resolved tag.
- cdb_taken  in  1  resolution outcome.
- redir_valid  out  1  head entry is resolved-taken.
- redir_ready  in  1  IFQ accepts the redirect.
- redir_addr  out  PC_W  target address of the head entry.
- count  out  $clog2(DEPTH)+1  number of live entries.

Behaviour:
- Target computation, modulo 2^PC_W:
  - Branch: disp_pc + (sign_extend(disp_imm) << 2).
  - Jump: {disp_pc[PC_W-1:JTGT_W+2], disp_jtgt, 2'b00}.
- Per-entry state: FREE, PEND, TAKEN, NTAKEN.
  - Dispatch handshake (disp_valid & disp_ready) writes the tail entry and computes its target.
  - A jump enters TAKEN; a branch enters PEND.
- Resolution: cdb_valid matching the tag of a PEND entry moves it to TAKEN if cdb_taken=1, otherwise NTAKEN.
  - Resolution may arrive in any order across entries.
  - A CDB match is never made against an entry being dispatched in the same cycle; upstream resolves no earlier than the cycle after dispatch.
  - A CDB tag with no PEND match is ignored.
- Head processing each cycle:
  - PEND: stall.
  - NTAKEN: pop silently in that cycle.
  - TAKEN: redir_valid=1, redir_addr = head target; hold stable until redir_ready.
- Redirect handshake (redir_valid & redir_ready): pop the head, clear every younger entry to FREE, reset head, tail and count to 0, and discard any dispatch in that same cycle.
- Latency:
  - A jump dispatched at cycle t into an empty queue gives redir_valid at t+1.
  - A branch resolved taken at cycle t while at head gives redir_valid at t+1.
- Ordering: pop and dispatch in the same cycle are both performed and count is unchanged.
  - disp_ready depends on registered count only; there is no combinational path from redir_ready or cdb to disp_ready.
- Priority: reset > flush > redirect-squash > normal pop/dispatch/resolve.
  - flush empties the queue in the next cycle and discards same-cycle dispatch and CDB events.
- Full: with count == DEPTH, disp_ready=0 and disp_valid is ignored.
- Empty: redir_valid=0 and redir_addr=0.
- Pointers wrap modulo DEPTH.
- Reset values: all entries FREE; head, tail and count = 0; disp_ready=1; redir_valid=0; redir_addr=0.
  - Reset mid-handshake abandons any pending redirect.

Decomposition:
- Package branch_redirect_pkg:
  - Entry-state enum (FREE/PEND/TAKEN/NTAKEN).
  - Entry struct {state, tag, target}.
  - Default width constants.
- Sub-module branch_target_calc: purely combinational jump/branch target computation, parametrised by PC_W, IMM_W and JTGT_W.
  - Instantiated once, on the dispatch path.

Test Plan:
- Jump: pc=0x0_0040_0010, jtgt=0x0100040, queue empty -> redir_valid at next cycle with redir_addr=0x0_0040_0100; redir_ready=1 -> count=0.
- Backward branch: pc=0x1000, imm=0xFFFC, tag 3; CDB tag 3 taken two cycles later -> redir_addr=0x0FF0; then plain pc+(imm<<2) with imm=0x0004 -> 0x1010.
- Out-of-order resolution: branches tags 1,2,3 dispatched; CDB 3 taken, 2 not-taken, then 1 not-taken -> head 1 and 2 pop silently, redirect to tag 3 target, count=0.
- Squash: jump behind a pending branch, branch resolves taken; redir_ready=1 with a simultaneous dispatch -> redirect = branch target, jump and new dispatch discarded, count=0.
- Full/backpressure: 4 branches dispatched, disp_ready=0, 5th disp_valid ignored; head resolves not-taken while dispatching -> count stays 4.
- flush or reset asserted while redir_valid=1 and redir_ready=0 -> next cycle redir_valid=0, count=0, disp_ready=1.
